// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Registered immediate generator for the decode stage. Each accepted
// instruction is decoded combinationally on the input side. The decoded
// immediate, its format code and a sideband tag are captured on the accept
// edge. A main register drives the outputs. A skid register catches one extra
// entry while the consumer stalls, so in_ready can be a pure register output
// and throughput stays at one entry per cycle.
//
// Format codes: I=0, S=1, B=2, U=3, J=4, Z=5, SH=6, ILL=7.
//
// Parameters
//   XLEN      : datapath width, 32 or 64
//   TAG_W     : sideband tag width
//   AUTO_TYPE : 1 = format decoded from opcode/funct3, 0 = taken from in_imm_type
//
// Ports
//   clk          : clock
//   rst_n        : synchronous active-low reset
//   flush        : drop all buffered entries (and any input this cycle)
//   in_valid     : input instruction valid
//   in_ready     : block accepts an input this cycle (registered)
//   in_inst      : 32-bit instruction word
//   in_imm_type  : format selector, used only when AUTO_TYPE=0
//   in_tag       : sideband tag
//   out_valid    : output entry valid
//   out_ready    : consumer accepts the output this cycle
//   out_imm      : sign/zero-extended immediate
//   out_type     : resolved format code
//   out_tag      : tag of the output entry
//   out_illegal  : format unresolvable; out_imm is 0
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 5,
  parameter bit AUTO_TYPE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_imm_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef enum logic [2:0] {
    T_I   = 3'd0,
    T_S   = 3'd1,
    T_B   = 3'd2,
    T_U   = 3'd3,
    T_J   = 3'd4,
    T_Z   = 3'd5,
    T_SH  = 3'd6,
    T_ILL = 3'd7
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       typ;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  imm_type_e   dec_type;
  logic        sh5;       // shift amount forced to 5 bits (RV64 *W shifts)
  logic [31:0] v32;       // 32-bit form; bit 31 drives the XLEN extension
  logic [XLEN-1:0] dec_imm;
  entry_t      dec_entry;

  // Instruction fields not consumed by every configuration.
  logic unused_bits;
  assign unused_bits = ^{in_imm_type, in_inst[6:0]};

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];

  always_comb begin
    dec_type = T_ILL;
    sh5      = 1'b0;
    if (AUTO_TYPE) begin
      case (opcode)
        7'b0010011: dec_type = (funct3 == 3'b001 || funct3 == 3'b101) ? T_SH : T_I;
        7'b0011011: begin
          // OP-IMM-32 exists only on RV64; its shifts take a 5-bit shamt.
          if (XLEN == 64) begin
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
              dec_type = T_SH;
              sh5      = 1'b1;
            end else begin
              dec_type = T_I;
            end
          end else begin
            dec_type = T_ILL;
          end
        end
        7'b0000011,
        7'b1100111,
        7'b0001111: dec_type = T_I;
        7'b0100011: dec_type = T_S;
        7'b1100011: dec_type = T_B;
        7'b0110111,
        7'b0010111: dec_type = T_U;
        7'b1101111: dec_type = T_J;
        7'b1110011: dec_type = funct3[2] ? T_Z : T_I;
        default:    dec_type = T_ILL;
      endcase
    end else begin
      dec_type = imm_type_e'(in_imm_type);
    end
  end

  always_comb begin
    v32 = 32'd0;
    case (dec_type)
      T_I:  v32 = {{20{in_inst[31]}}, in_inst[31:20]};
      T_S:  v32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      T_B:  v32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
      T_U:  v32 = {in_inst[31:12], 12'd0};
      T_J:  v32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
      T_Z:  v32 = {27'd0, in_inst[19:15]};
      T_SH: begin
        if (XLEN == 64 && !sh5) v32 = {26'd0, in_inst[25:20]};
        else                    v32 = {27'd0, in_inst[24:20]};
      end
      default: v32 = 32'd0;
    endcase
  end

  // Z and SH keep bit 31 clear, so one signed extension covers every format.
  assign dec_imm = XLEN'($signed(v32));

  always_comb begin
    dec_entry     = '0;
    dec_entry.imm = dec_imm;
    dec_entry.typ = dec_type;
    dec_entry.tag = in_tag;
    dec_entry.ill = (dec_type == T_ILL);
  end

  // ---------------------------------------------------------------------------
  // Two-entry skid buffer
  // ---------------------------------------------------------------------------
  entry_t main_reg, main_next;
  entry_t skid_reg, skid_next;
  logic   main_valid_reg, main_valid_next;
  logic   skid_valid_reg, skid_valid_next;
  logic   in_ready_reg, in_ready_next;
  logic   accept, consume;

  assign accept  = in_valid && in_ready_reg;
  assign consume = main_valid_reg && out_ready;

  always_comb begin
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;

    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (consume) begin
      // in_ready is low whenever skid is full, so accept and a skid
      // promotion never coincide.
      if (skid_valid_reg) begin
        main_next       = skid_reg;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        main_next = dec_entry;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_reg) begin
        skid_next       = dec_entry;
        skid_valid_next = 1'b1;
      end else begin
        main_next       = dec_entry;
        main_valid_next = 1'b1;
      end
    end

    in_ready_next = !skid_valid_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= in_ready_next;
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = main_valid_reg;
  assign out_imm     = main_reg.imm;
  assign out_type    = main_reg.typ;
  assign out_tag     = main_reg.tag;
  assign out_illegal = main_reg.ill;

endmodule
